synth_frame_decoder: RTL and testbench
======================================

Name: synth_frame_decoder

Overview:
- Receiving end of the packed synthesis-test output vector.
- Accepts the 31-bit frame {o1[11:0], o2[1:0], o3, o4[14:0], o5} bit-serially, MSB first, from a test-harness serial link.
- Majority-decodes the replicated i1 copies and recovers i2.
- Checks all constant fields and keeps frame and error statistics for regression benches.

Parameters:
FRAME_W, 31, frame length in bits; fixed by the frame layout, not for override.
CNT_W, 8, width of frame_cnt and err_cnt.

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
sdi  input  1  serial data bit
sdi_valid  input  1  sdi is sampled only when high
sof  input  1  start of frame; qualified by sdi_valid; marks the MSB (bit 30)
out_valid  output  1  one-cycle pulse: decoded fields valid
dec_i1  output  2  decoded i1
dec_i2  output  1  decoded i2
err_vote  output  1  replica copies of i1 not unanimous (held with dec_*)
err_const  output  1  a constant field is wrong (held with dec_*)
frame_abort  output  1  one-cycle pulse: partial frame discarded by new sof
frame_cnt  output  CNT_W  completed frames, wraps
err_cnt  output  CNT_W  frames with err_vote|err_const, saturates at all-ones

Behaviour:
- Frame bit map (bit 30 first):
  - o1 = bits 30:19; o2 = 18:17; o3 = 16; o4 = 15:1; o5 = 0.
  - i1[1] copies: o1[11:5], o1[4], o1[2] (9 copies).
  - i1[0] copies: o1[3], o1[1], o1[0] (3 copies).
  - i2 = o2[0].
  - Constants: o2[1]=0, o3=0, o4=0, o5=1.
- FSM states: IDLE, SHIFT. 5-bit bit counter; 31-bit shift register.
- IDLE:
  - sdi_valid & sof: load sdi as bit 30, count=1, go to SHIFT.
  - sdi_valid without sof: bit ignored.
- SHIFT:
  - sdi_valid low: stall; no state change.
  - sdi_valid & !sof: shift in, count+1.
  - sdi_valid & sof: frame_abort=1 next cycle; restart with this bit as bit 30, count=1; no counters touched.
  - On the 31st accepted bit: decode and go to IDLE.
- Decode at completion, registered; out_valid high the cycle after the 31st bit is sampled:
  - dec_i1[1] = 1 if at least 5 of 9 copies are 1.
  - dec_i1[0] = 1 if at least 2 of 3 copies are 1.
  - dec_i2 = o2[0].
  - err_vote = either copy group not all-equal.
  - err_const = any constant mismatch.
- dec_i1, dec_i2, err_vote and err_const hold until the next completed frame.
- Back-to-back frames: sof with sdi_valid is accepted in the same cycle out_valid is high; zero-bubble streaming is supported.
- frame_cnt increments on every completion and wraps from all-ones to 0.
- err_cnt increments when (err_vote|err_const) at completion and sticks at all-ones.
- Reset (any time, including mid-frame):
  - state IDLE; shift register and count cleared.
  - All outputs 0; out_valid and frame_abort low.
  - Partial frame lost; no pulse is generated.

Test Plan:
- Reset, then stream 0x7FA20001 with sof on first bit and sdi_valid continuous -> out_valid pulse exactly 31 cycles after sof cycle; dec_i1=2'b10, dec_i2=1, err_vote=0, err_const=0, frame_cnt=1, err_cnt=0.
- Stream 0x00580001 with random sdi_valid gaps -> dec_i1=2'b01, dec_i2=0, no errors; out_valid one cycle after 31st valid bit; frame_cnt=1.
- Stream 0x3FA20001 (one i1[1] copy flipped) -> dec_i1=2'b10, err_vote=1, err_const=0, err_cnt=1.
- Stream 0x7FA20003 (o4 nonzero) then 0x7FA20000 (o5=0) back-to-back -> two consecutive out_valid frames 31 cycles apart, err_const=1 both, err_cnt=2.
- Assert sof again after 10 bits, then a full 0x7FA20001 -> frame_abort pulse once, one out_valid only, frame_cnt=1.
- Assert reset at bit 20 of a frame, release, send 0x00580001 -> all outputs 0 during reset, then dec_i1=2'b01, frame_cnt=1; send 300 error frames -> err_cnt holds 255, frame_cnt wraps to 45.

Source files
------------

// File: rtl/synth_frame_decoder.sv
// Serial receiver for the packed synthesis-test output frame.
// Shifts in a 31-bit frame MSB first, majority-decodes the replicated i1
// copies, recovers i2, checks the constant fields and keeps frame/error counts.
module synth_frame_decoder #(
    parameter int unsigned FRAME_W = 31,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sdi,
    input  logic             sdi_valid,
    input  logic             sof,
    output logic             out_valid,
    output logic [1:0]       dec_i1,
    output logic             dec_i2,
    output logic             err_vote,
    output logic             err_const,
    output logic             frame_abort,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [0:0] {StIdle, StShift} state_t;

    // Count value holding the 30th accepted bit; the next accepted bit completes the frame.
    localparam logic [4:0] LastCnt = 5'(FRAME_W - 1);

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;

    // Frame as it stands once the current bit is appended; only meaningful on completion.
    logic [FRAME_W-1:0] frame;
    logic               done;
    logic               abort;

    logic [8:0]         hi_copies;
    logic [2:0]         lo_copies;
    logic [3:0]         hi_ones;
    logic               vote_hi;
    logic               vote_lo;
    logic               vote_err;
    logic               const_err;

    assign frame = {shreg_q[FRAME_W-2:0], sdi};

    // Next-state logic: frame acceptance, stalls, restarts and completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        abort   = 1'b0;
        if (sdi_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (sof) begin
                        shreg_d = {{(FRAME_W-1){1'b0}}, sdi};
                        cnt_d   = 5'd1;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (sof) begin
                        // New sof mid-frame: drop the partial frame and restart on this bit.
                        abort   = 1'b1;
                        shreg_d = {{(FRAME_W-1){1'b0}}, sdi};
                        cnt_d   = 5'd1;
                    end else if (cnt_q == LastCnt) begin
                        done    = 1'b1;
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        shreg_d = frame;
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Field decode of the completed frame: i1 replicas, i2 and constant checks.
    always_comb begin
        // i1[1] lives in o1[11:5], o1[4], o1[2]; i1[0] in o1[3], o1[1], o1[0].
        hi_copies = {frame[30:24], frame[23], frame[21]};
        lo_copies = {frame[22], frame[20], frame[19]};
        hi_ones   = 4'($countones(hi_copies));
        vote_hi   = (hi_ones >= 4'd5);
        vote_lo   = (lo_copies[2] & lo_copies[1]) | (lo_copies[2] & lo_copies[0])
                  | (lo_copies[1] & lo_copies[0]);
        vote_err  = ~((&hi_copies) | ~(|hi_copies)) | ~((&lo_copies) | ~(|lo_copies));
        // o2[1], o3 and o4 must be zero; o5 must be one.
        const_err = frame[18] | frame[16] | (|frame[15:1]) | ~frame[0];
    end

    // FSM state, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Registered results, pulses and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            frame_abort <= 1'b0;
            dec_i1      <= 2'b00;
            dec_i2      <= 1'b0;
            err_vote    <= 1'b0;
            err_const   <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            out_valid   <= done;
            frame_abort <= abort;
            if (done) begin
                dec_i1    <= {vote_hi, vote_lo};
                dec_i2    <= frame[17];
                err_vote  <= vote_err;
                err_const <= const_err;
                frame_cnt <= frame_cnt + CNT_W'(1);
                if ((vote_err | const_err) && (err_cnt != {CNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_synth_frame_decoder.sv
// Self-checking bench for synth_frame_decoder: queue-based frame model compared
// every cycle, plus directed frames with hand-computed expectations.
module tb_synth_frame_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sdi = 1'b0;
    logic       sdi_valid = 1'b0;
    logic       sof = 1'b0;
    logic       out_valid;
    logic [1:0] dec_i1;
    logic       dec_i2;
    logic       err_vote;
    logic       err_const;
    logic       frame_abort;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    synth_frame_decoder #(
        .FRAME_W(31),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sdi        (sdi),
        .sdi_valid  (sdi_valid),
        .sof        (sof),
        .out_valid  (out_valid),
        .dec_i1     (dec_i1),
        .dec_i2     (dec_i2),
        .err_vote   (err_vote),
        .err_const  (err_const),
        .frame_abort(frame_abort),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Decode a whole frame from the field rules: returns {i1[1], i1[0], i2, err_vote, err_const}.
    function automatic logic [4:0] model_decode(input logic [30:0] f);
        logic [11:0] o1;
        int          hi;
        int          lo;
        logic        ev;
        logic        ec;
        o1 = f[30:19];
        hi = 0;
        for (int k = 5; k <= 11; k++) hi += int'(o1[k]);
        hi += int'(o1[4]);
        hi += int'(o1[2]);
        lo = int'(o1[3]);
        lo += int'(o1[1]);
        lo += int'(o1[0]);
        ev = ((hi != 0) && (hi != 9)) || ((lo != 0) && (lo != 3));
        ec = (f[18] != 1'b0) || (f[16] != 1'b0) || (f[15:1] != 15'd0) || (f[0] != 1'b1);
        return {(hi >= 5), (lo >= 2), f[17], ev, ec};
    endfunction

    // Model state: bits collected so far plus expected output values.
    bit         mbits[$];
    logic       exp_valid = 1'b0;
    logic       exp_abort = 1'b0;
    logic [4:0] exp_fields = 5'd0;
    int         exp_fc = 0;
    int         exp_errs = 0;

    initial forever begin
        logic [30:0] f;
        logic [4:0]  d;
        @(posedge clk or posedge reset);
        if (reset) begin
            mbits.delete();
            exp_valid  = 1'b0;
            exp_abort  = 1'b0;
            exp_fields = 5'd0;
            exp_fc     = 0;
            exp_errs   = 0;
        end else begin
            exp_valid = 1'b0;
            exp_abort = 1'b0;
            if (sdi_valid) begin
                if (sof) begin
                    if (mbits.size() > 0) exp_abort = 1'b1;
                    mbits.delete();
                    mbits.push_back(sdi);
                end else if (mbits.size() > 0) begin
                    mbits.push_back(sdi);
                end
                if (mbits.size() == 31) begin
                    for (int i = 0; i < 31; i++) f[30-i] = mbits[i];
                    mbits.delete();
                    d          = model_decode(f);
                    exp_valid  = 1'b1;
                    exp_fields = d;
                    exp_fc     = (exp_fc + 1) % 256;
                    if (d[1] || d[0]) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
                end
            end
        end
    end

    // Per-cycle compare and event log (out_valid edges/fields, abort pulses).
    int         cyc = 0;
    int         sof_edge = -1;
    int         ov_edge[$];
    logic [4:0] ov_fields[$];
    int         abort_cnt = 0;

    initial forever begin
        logic samp;
        @(posedge clk);
        cyc++;
        samp = sdi_valid && sof && !reset;
        #1;
        check($sformatf("cycle_%0d", cyc),
              {8'd0, out_valid, frame_abort, dec_i1, dec_i2, err_vote, err_const,
               frame_cnt, err_cnt},
              {8'd0, exp_valid, exp_abort, exp_fields, 8'(exp_fc), 8'(exp_errs)});
        if (samp) sof_edge = cyc;
        if (out_valid) begin
            ov_edge.push_back(cyc);
            ov_fields.push_back({dec_i1, dec_i2, err_vote, err_const});
        end
        if (frame_abort) abort_cnt++;
    end

    function automatic int ov_edge_at(input int i);
        return (i < ov_edge.size()) ? ov_edge[i] : -1000;
    endfunction

    function automatic logic [4:0] ov_fields_at(input int i);
        return (i < ov_fields.size()) ? ov_fields[i] : 5'bxxxxx;
    endfunction

    task automatic clear_log();
        ov_edge.delete();
        ov_fields.delete();
        abort_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        sdi_valid = 1'b0;
        sof       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic idle();
        @(negedge clk);
        sdi_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Gap cycles carry random sdi/sof with sdi_valid low; they must be ignored.
    task automatic send_bit(input logic b, input logic s, input int gap);
        repeat (gap) begin
            @(negedge clk);
            sdi_valid = 1'b0;
            sof       = 1'($urandom_range(0, 1));
            sdi       = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        sdi_valid = 1'b1;
        sof       = s;
        sdi       = b;
    endtask

    task automatic send_bits(input logic [30:0] f, input int nbits, input int maxgap);
        for (int i = 30; i > 30 - nbits; i--) begin
            send_bit(f[i], i == 30, (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        end
    endtask

    // Outputs as seen in the cycle right after the last bit was sampled.
    task automatic check_result(input string t, input logic [4:0] fields, input int fc,
                                input int ec);
        check({t, "_out_valid"}, out_valid, 1'b1);
        check({t, "_fields"}, {dec_i1, dec_i2, err_vote, err_const}, fields);
        check({t, "_frame_cnt"}, frame_cnt, fc);
        check({t, "_err_cnt"}, err_cnt, ec);
    endtask

    initial begin
        // Pin the model's decode with hand-derived values.
        check("model_7FA20001", model_decode(31'h7FA20001), 5'b10100);
        check("model_00580001", model_decode(31'h00580001), 5'b01000);
        check("model_3FA20001", model_decode(31'h3FA20001), 5'b10110);

        repeat (3) @(negedge clk);
        check("reset_state", {out_valid, frame_abort, dec_i1, dec_i2, err_vote, err_const,
                              frame_cnt, err_cnt}, 24'd0);
        reset = 1'b0;
        clear_log();

        // Continuous stream, nominal frame.
        send_bits(31'h7FA20001, 31, 0);
        idle();
        check_result("t1", 5'b10100, 1, 0);
        check("t1_latency", ov_edge_at(0) - sof_edge, 30);
        idle();
        check("t1_pulse_width", out_valid, 1'b0);
        check("t1_hold", {dec_i1, dec_i2}, 3'b101);

        // Random gaps, leading bits without sof ignored in idle.
        do_reset();
        repeat (4) send_bit(1'b1, 1'b0, 0);
        send_bits(31'h00580001, 31, 3);
        idle();
        check_result("t2", 5'b01000, 1, 0);
        idle();
        check("t2_pulse_width", out_valid, 1'b0);

        // One i1[1] replica flipped.
        do_reset();
        send_bits(31'h3FA20001, 31, 0);
        idle();
        check_result("t3", 5'b10110, 1, 1);

        // Back-to-back constant errors.
        do_reset();
        send_bits(31'h7FA20003, 31, 0);
        send_bits(31'h7FA20000, 31, 0);
        idle();
        check_result("t4", 5'b10101, 2, 2);
        check("t4_ov_count", ov_edge.size(), 2);
        check("t4_spacing", ov_edge_at(1) - ov_edge_at(0), 31);
        check("t4_first_fields", ov_fields_at(0), 5'b10101);

        // Restart after 10 bits.
        do_reset();
        send_bits(31'h7FA20001, 10, 0);
        send_bits(31'h7FA20001, 31, 0);
        idle();
        check_result("t5", 5'b10100, 1, 0);
        idle();
        check("t5_abort_count", abort_cnt, 1);
        check("t5_ov_count", ov_edge.size(), 1);

        // Reset at bit 20 of a frame; state from t5 is still live.
        clear_log();
        send_bits(31'h7FA20003, 20, 0);
        @(negedge clk);
        reset     = 1'b1;
        sdi_valid = 1'b0;
        sof       = 1'b0;
        @(negedge clk);
        check("t6_in_reset", {out_valid, frame_abort, dec_i1, dec_i2, err_vote, err_const,
                              frame_cnt, err_cnt}, 24'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) idle();
        check("t6_no_pulses", ov_edge.size() + abort_cnt, 0);
        send_bits(31'h00580001, 31, 0);
        idle();
        check_result("t6", 5'b01000, 1, 0);
        for (int n = 0; n < 300; n++) send_bits(31'h7FA20000, 31, 0);
        idle();
        check_result("t6_sat", 5'b10101, 45, 255);
        repeat (2) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
